gouram_trace_merger: RTL
========================

// Module: gouram_trace_merger
// PURPOSE
// Merges the trace records of NUM_CHANNELS gouram trace cores (one per traced hart/port)
// into a single buffered record stream for the trace sink.
// - Per-channel FIFO; round-robin arbitration; registered valid/ready output.
// - Per-channel lock (almost-full) back-pressure; saturating drop counter for records lost on overflow.
// - Sits between the gouram instances and the trace capture/offload logic.
// PARAMETERS
// NUM_CHANNELS     4    number of trace sources (>=1)
// TRACE_WIDTH      128  bits per trace record
// FIFO_DEPTH       8    records per channel FIFO (power of 2, >=2)
// LOCK_MARGIN      2    lock_o[i] asserts when FIFO count >= FIFO_DEPTH-LOCK_MARGIN (0..FIFO_DEPTH-1)
// DROP_CNT_WIDTH   16   width of drop counter
// CH_W             $clog2(NUM_CHANNELS) (min 1), derived
// PORTS
// clk                     in   1                        clock
// rst_n                   in   1                        asynchronous reset, active low
// trace_data_i            in   NUM_CHANNELS*TRACE_WIDTH channel i record at [i*TRACE_WIDTH +: TRACE_WIDTH]
// trace_capture_enable_i  in   NUM_CHANNELS             push strobe per channel, one record per cycle per channel
// trace_data_o            out  TRACE_WIDTH              merged record
// trace_channel_o         out  CH_W                     source channel of trace_data_o
// trace_valid_o           out  1                        trace_data_o/trace_channel_o valid
// trace_ready_i           in   1                        sink accepts when valid&&ready at rising edge
// lock_o                  out  NUM_CHANNELS             per-channel almost-full
// drop_count_o            out  DROP_CNT_WIDTH           total dropped records, all channels
// drop_clr_i              in   1                        synchronous clear of drop_count_o
// BEHAVIOUR
// Reset (async, rst_n=0): all FIFOs empty; trace_valid_o=0; trace_data_o=0; trace_channel_o=0;
//   lock_o=0 (unless LOCK_MARGIN>=FIFO_DEPTH-0, not allowed); drop_count_o=0; RR pointer=0.
//   Reset mid-stream discards all buffered and in-flight records; no partial output.
// Push: enable[i] at edge writes record into FIFO i if count_i<FIFO_DEPTH, or if count_i==FIFO_DEPTH
//   and FIFO i is popped at the same edge (simultaneous push/pop on full is accepted).
//   Otherwise record dropped; drop counter +1 per dropped record (several channels same cycle -> +k).
// Drop counter saturates at all-ones; drop_clr_i has priority over increments in the same cycle.
// Output stage: one register. Loads when !trace_valid_o or (trace_valid_o && trace_ready_i).
//   While valid && !ready: trace_data_o/trace_channel_o held stable, valid held high.
//   Full throughput: one record per cycle when ready held high.
// Arbitration: among non-empty FIFOs at load time, grant first channel at or after rr_ptr (wrapping);
//   after grant rr_ptr = granted+1 mod NUM_CHANNELS. rr_ptr unchanged when no grant.
//   Only FIFO contents are arbitrated (no bypass from trace_data_i).
// Latency: record pushed at edge N into empty system -> trace_valid_o high after edge N+1 (2 cycles
//   from enable sampled). Per-channel order preserved.
// lock_o[i] = (count_i >= FIFO_DEPTH-LOCK_MARGIN), from registered count; no glitches.
// Effective capacity per channel = FIFO_DEPTH, plus the shared output register.
// FIFO pointers wrap modulo FIFO_DEPTH; count has log2(FIFO_DEPTH)+1 bits.
// TESTING
// 1 ch0 push 0xA5A5..A5, ready=1 -> valid 2 cycles later, data 0xA5A5..A5, channel 0, valid 1 cycle.
// 2 ch0..3 push same cycle, ready=1 -> 4 consecutive valid cycles, channels 0,1,2,3; next burst starts ch0.
// 3 ready=0, ch1 pushes 11 back-to-back (DEPTH=8) -> lock_o[1] once count=6; 8 in FIFO, 1 in output reg;
//   drop_count_o=2; then ready=1 -> exactly 9 records out, in push order.
// 4 ready toggling 1010.. with ch2 streaming -> data/channel stable whenever valid&&!ready; no loss/duplicate.
// 5 rst_n pulsed low mid-stream -> valid low immediately, lock_o=0, drop_count_o=0; next push appears after 2 cycles.
// 6 DROP_CNT_WIDTH=4, 20 drops -> drop_count_o holds 15; drop_clr_i with concurrent drop -> 0.

Source files
------------

// File: rtl/gouram_trace_merger.sv
// Merges per-hart gouram trace records into one buffered stream: a FIFO per channel,
// round-robin arbitration into a single registered valid/ready output stage.
module gouram_trace_merger #(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned TRACE_WIDTH    = 128,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned LOCK_MARGIN    = 2,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  parameter int unsigned CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS*TRACE_WIDTH-1:0]  trace_data_i,
  input  logic [NUM_CHANNELS-1:0]              trace_capture_enable_i,
  output logic [TRACE_WIDTH-1:0]               trace_data_o,
  output logic [CH_W-1:0]                      trace_channel_o,
  output logic                                 trace_valid_o,
  input  logic                                 trace_ready_i,
  output logic [NUM_CHANNELS-1:0]              lock_o,
  output logic [DROP_CNT_WIDTH-1:0]            drop_count_o,
  input  logic                                 drop_clr_i
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned NDropW = $clog2(NUM_CHANNELS + 1);

  logic [NUM_CHANNELS-1:0] not_empty;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;
  logic [TRACE_WIDTH-1:0]  head [NUM_CHANNELS];

  logic                    load;
  logic                    grant_vld;
  logic [CH_W-1:0]         grant_idx;
  logic [CH_W-1:0]         cand;
  int unsigned             arb_idx;
  logic [CH_W-1:0]         rr_q, rr_d;

  logic                    valid_q, valid_d;
  logic [TRACE_WIDTH-1:0]  data_q, data_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [NDropW-1:0]       n_drop;
  logic [DROP_CNT_WIDTH:0] drop_sum;

  // Output register may take a new record whenever it is empty or being drained this cycle.
  assign load = !valid_q || trace_ready_i;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [PtrW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [TRACE_WIDTH-1:0] mem [FIFO_DEPTH];

    assign not_empty[g] = (cnt_q != '0);
    assign pop[g]       = load && grant_vld && (grant_idx == CH_W'(g));
    // A full FIFO still accepts when its head leaves at the same edge.
    assign push[g]      = trace_capture_enable_i[g] &&
                          ((cnt_q != CntW'(FIFO_DEPTH)) || pop[g]);
    assign lock_o[g]    = (cnt_q >= CntW'(FIFO_DEPTH - LOCK_MARGIN));
    assign head[g]      = mem[rd_q];

    always_comb begin
      wr_d  = wr_q + PtrW'(push[g]);
      rd_d  = rd_q + PtrW'(pop[g]);
      cnt_d = cnt_q + CntW'(push[g]) - CntW'(pop[g]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[g]) begin
        mem[wr_q] <= trace_data_i[g*TRACE_WIDTH +: TRACE_WIDTH];
      end
    end
  end

  // Round-robin: first non-empty channel at or after rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      arb_idx = (32'(rr_q) + k) % NUM_CHANNELS;
      cand    = CH_W'(arb_idx);
      if (!grant_vld && not_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    rr_d    = rr_q;
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    if (load) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        data_d = head[grant_idx];
        chan_d = grant_idx;
        rr_d   = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
      end
    end
  end

  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      n_drop = n_drop + NDropW'(trace_capture_enable_i[i] && !push[i]);
    end
    drop_sum = {1'b0, drop_q} + (DROP_CNT_WIDTH + 1)'(n_drop);
    if (drop_clr_i) begin
      drop_d = '0;
    end else if (drop_sum[DROP_CNT_WIDTH]) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[DROP_CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      drop_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      drop_q  <= drop_d;
    end
  end

  assign trace_valid_o   = valid_q;
  assign trace_data_o    = data_q;
  assign trace_channel_o = chan_q;
  assign drop_count_o    = drop_q;

endmodule
